ultrasonic_ranger_mc: RTL

Multi-channel ultrasonic ranging engine that sequences NCH HC-SR04-style sensors round-robin from a single 1 MHz timebase. It converts each echo width directly to centimetres, without a divider, and flags rise and fall timeouts per channel. It feeds display and servo-compare logic through a per-channel result bank plus a one-cycle result strobe. A guard interval between channels suppresses acoustic crosstalk.

---
 rtl/ultrasonic_pkg.sv | 28 ++
 rtl/echo_sync.sv | 31 +++
 rtl/ultrasonic_ranger_mc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared types and defaults for the ultrasonic ranger.
// Holds the FSM state enum, timing defaults and a bank slice helper.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_WAIT_FALL,
      S_REPORT,
      S_GUARD
   } state_e;

   localparam int unsigned DEF_TRIG_US     = 10;
   localparam int unsigned DEF_RISE_TMO_US = 30000;
   localparam int unsigned DEF_FALL_TMO_US = 25000;
   localparam int unsigned DEF_GUARD_US    = 2000;
   localparam int unsigned DEF_CM_DIV      = 58;

   // Low bit of channel k inside a packed bank of w-bit fields
   function automatic int unsigned slice_lo(
      input int unsigned k,
      input int unsigned w
   );
      return k * w;
   endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync: two-flop synchroniser for one echo line plus edge pulses.
// Ports: clk_1mhz, nrst, echo_i (async) -> rise_o, fall_o (1-cycle pulses).
module echo_sync (
   input  logic clk_1mhz,
   input  logic nrst,
   input  logic echo_i,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk_1mhz or negedge nrst) begin
      if (!nrst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= echo_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // s2_q is the synchronised level; s3_q its previous value
   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc: round-robin HC-SR04 ranging engine, echo width to cm.
// Ports: start/echo in; trigger, busy, res_* strobe, dist_cm bank, err out.
module ultrasonic_ranger_mc
   import ultrasonic_pkg::*;
#(
   parameter int unsigned NCH         = 4,
   parameter int unsigned TRIG_US     = DEF_TRIG_US,
   parameter int unsigned RISE_TMO_US = DEF_RISE_TMO_US,
   parameter int unsigned FALL_TMO_US = DEF_FALL_TMO_US,
   parameter int unsigned GUARD_US    = DEF_GUARD_US,
   parameter int unsigned CM_DIV      = DEF_CM_DIV,
   parameter int unsigned DIST_W      = 9,
   parameter int unsigned CNT_W       = 16,
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk_1mhz,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [NCH-1:0]        echo,
   output logic [NCH-1:0]        trigger,
   output logic                  busy,
   output logic                  res_valid,
   output logic [CHW-1:0]        res_ch,
   output logic [DIST_W-1:0]     res_cm,
   output logic                  res_err,
   output logic [NCH*DIST_W-1:0] dist_cm,
   output logic [NCH-1:0]        err
);

   localparam int unsigned SUB_W = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

   localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_US - 1);
   localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(RISE_TMO_US - 1);
   localparam logic [CNT_W-1:0] FALL_LAST  = CNT_W'(FALL_TMO_US - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_US - 1);
   localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CM_DIV - 1);
   localparam logic [CHW-1:0]   CH_LAST    = CHW'(NCH - 1);

   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;

   for (genvar k = 0; k < NCH; k++) begin : g_sync
      echo_sync u_sync (
         .clk_1mhz (clk_1mhz),
         .nrst     (nrst),
         .echo_i   (echo[k]),
         .rise_o   (rise[k]),
         .fall_o   (fall[k])
      );
   end

   state_e                state_q, state_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic [CNT_W-1:0]      timer_q, timer_d;
   logic [SUB_W-1:0]      sub_q, sub_d;
   logic [DIST_W-1:0]     cm_q, cm_d;
   logic                  tmo_q, tmo_d;
   logic [NCH*DIST_W-1:0] dist_q, dist_d;
   logic [NCH-1:0]        err_q, err_d;

   always_ff @(posedge clk_1mhz or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         timer_q <= '0;
         sub_q   <= '0;
         cm_q    <= '0;
         tmo_q   <= 1'b0;
         dist_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         timer_q <= timer_d;
         sub_q   <= sub_d;
         cm_q    <= cm_d;
         tmo_q   <= tmo_d;
         dist_q  <= dist_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      timer_d = timer_q;
      sub_d   = sub_q;
      cm_d    = cm_q;
      tmo_d   = tmo_q;
      dist_d  = dist_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ch_d    = '0;
               timer_d = '0;
               state_d = S_TRIG;
            end
         end
         S_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               timer_d = '0;
               state_d = S_WAIT_RISE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_RISE: begin
            if (rise[ch_q]) begin
               timer_d = '0;
               sub_d   = '0;
               cm_d    = '0;
               tmo_d   = 1'b0;
               state_d = S_WAIT_FALL;
            end else if (timer_q == RISE_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_REPORT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_FALL: begin
            // Counting also on the fall cycle makes the count equal
            // the number of synchronised high cycles.
            timer_d = timer_q + 1'b1;
            if (sub_q == SUB_LAST) begin
               sub_d = '0;
               if (cm_q != '1) cm_d = cm_q + 1'b1;
            end else begin
               sub_d = sub_q + 1'b1;
            end
            if (fall[ch_q]) begin
               state_d = S_REPORT;
            end else if (timer_q == FALL_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            timer_d = '0;
            state_d = S_GUARD;
            if (tmo_q) begin
               err_d[ch_q] = 1'b1;
            end else begin
               err_d[ch_q] = 1'b0;
               dist_d[slice_lo(32'(ch_q), DIST_W) +: DIST_W] = cm_q;
            end
         end
         S_GUARD: begin
            if (timer_q == GUARD_LAST) begin
               timer_d = '0;
               if (ch_q == CH_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = S_TRIG;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      trigger   = '0;
      res_valid = 1'b0;
      res_ch    = '0;
      res_cm    = '0;
      res_err   = 1'b0;
      unique case (state_q)
         S_TRIG: trigger[ch_q] = 1'b1;
         S_REPORT: begin
            res_valid = 1'b1;
            res_ch    = ch_q;
            res_err   = tmo_q;
            res_cm    = tmo_q ? '0 : cm_q;
         end
         default: ;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign dist_cm = dist_q;
   assign err     = err_q;

endmodule
